// File: rtl/lamp_pkg.sv
// Shared encodings and widths for the lamp sequencer slice.
package lamp_pkg;

  localparam int CNT_W     = 4;
  localparam int MAX_LAMPS = 15;

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MAX_LAMPS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

endpackage

// File: rtl/lamp_step_div.sv
// Step divider: emits one step pulse on every STEP_DIV-th tick since the last clear.
module lamp_step_div
  import lamp_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic step
);

  logic [CNT_W-1:0] count;

  // Step is combinational so the lamp count moves on the same edge as the final tick.
  assign step = tick && (count == CNT_W'(STEP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || step) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lamp_sequencer.sv
// Ramps a thermometer-coded lamp bar one lamp per STEP_DIV ticks toward a latched goal.
// Optional LAMP_SEQ_INSTANT_OFF_EN: a target of 0 blanks the bar at once instead of ramping.
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int STEP_DIV  = 4,
  parameter int MAX_LAMPS = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     target,
  input  logic                 target_valid,
  input  logic                 step_tick,
  output logic [MAX_LAMPS-1:0] lamps,
  output logic [CNT_W-1:0]     lit_count,
  output logic                 busy,
  output logic                 done
);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] goal_reg;
  logic [CNT_W-1:0] lit_reg, lit_next;
  logic             arrive_reg, arrive_next;
  logic             done_reg;
  logic             step;
  logic             div_clear;

  assign busy = (state_reg == UP) || (state_reg == DOWN);

  // Direction is re-derived from the goal every cycle, so a retarget flips or ends the ramp.
  always_comb begin
    lit_next    = lit_reg;
    state_next  = state_reg;
    arrive_next = 1'b0;
    if (busy) begin
      if (step) begin
        if (state_reg == UP && lit_reg != MAX_COUNT) begin
          lit_next = lit_reg + 1'b1;
        end else if (state_reg == DOWN && lit_reg != '0) begin
          lit_next = lit_reg - 1'b1;
        end
      end
      if (goal_reg > lit_next) begin
        state_next = UP;
      end else if (goal_reg < lit_next) begin
        state_next = DOWN;
      end else begin
        state_next  = IDLE;
        arrive_next = 1'b1;
      end
    end else begin
      if (goal_reg > lit_reg) begin
        state_next = UP;
      end else if (goal_reg < lit_reg) begin
        state_next = DOWN;
      end else begin
        state_next = IDLE;
      end
    end
`ifdef LAMP_SEQ_INSTANT_OFF_EN
    if (target_valid && target == '0) begin
      lit_next    = '0;
      state_next  = IDLE;
      arrive_next = busy || (lit_reg != '0);
    end
`endif
  end

  assign div_clear = target_valid || (state_next != state_reg);

  lamp_step_div #(
    .STEP_DIV(STEP_DIV)
  ) u_step_div (
    .clk  (clk),
    .rst  (rst),
    .clear(div_clear),
    .tick (step_tick && busy),
    .step (step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      goal_reg   <= '0;
      lit_reg    <= '0;
      arrive_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lit_reg    <= lit_next;
      arrive_reg <= arrive_next;
      done_reg   <= arrive_reg;
      if (target_valid) begin
        goal_reg <= target;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_LAMPS; gi++) begin : g_lamp
      assign lamps[gi] = (lit_reg > CNT_W'(gi));
    end
  endgenerate

  assign lit_count = lit_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed + random bench for lamp_sequencer against a cycle-level behavioural model.
module tb_lamp_sequencer;

  localparam int STEP_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  target;
  logic        target_valid;
  logic        step_tick;
  logic [14:0] lamps;
  logic [3:0]  lit_count;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: goal, lit lamps, ramp direction (+1/-1/0), tick tally, done pipeline.
  int m_goal, m_lit, m_dir, m_ticks;
  bit m_arrive, m_done;

  int d_seen, busy_ticks, peak;

  lamp_sequencer #(.STEP_DIV(STEP_DIV), .MAX_LAMPS(15)) dut (
    .clk(clk), .rst(rst), .target(target), .target_valid(target_valid),
    .step_tick(step_tick), .lamps(lamps), .lit_count(lit_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  task automatic model_reset();
    m_goal = 0; m_lit = 0; m_dir = 0; m_ticks = 0; m_arrive = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit tv, input int tgt, input bit tk);
    int nl, nd;
    bit arr;
    nl  = m_lit;
    arr = 0;
    if (m_dir != 0) begin
      if (tk) begin
        m_ticks++;
        if (m_ticks == STEP_DIV) begin
          nl = m_lit + m_dir;
          if (nl > 15) nl = 15;
          if (nl < 0) nl = 0;
          m_ticks = 0;
        end
      end
      nd  = sgn(m_goal - nl);
      arr = (nd == 0);
    end else begin
      nd = sgn(m_goal - m_lit);
    end
`ifdef LAMP_SEQ_INSTANT_OFF_EN
    if (tv && tgt == 0) begin
      arr = (m_dir != 0) || (m_lit != 0);
      nl  = 0;
      nd  = 0;
    end
`endif
    if (tv || nd != m_dir) m_ticks = 0;
    if (tv) m_goal = tgt;
    m_done   = m_arrive;
    m_arrive = arr;
    m_lit    = nl;
    m_dir    = nd;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_lit"},   32'(lit_count), 32'(m_lit));
    chk({tag, "_lamps"}, 32'(lamps),     32'((1 << m_lit) - 1));
    chk({tag, "_busy"},  32'(busy),      32'(m_dir != 0));
    chk({tag, "_done"},  32'(done),      32'(m_done));
  endtask

  // One clock: drive inputs, let the edge pass, update model, sample 1 time unit later.
  task automatic cycle(input bit tv, input int tgt, input bit tk, input string tag);
    target_valid = tv;
    target       = 4'(tgt);
    step_tick    = tk;
    @(posedge clk);
    model_edge(tv, tgt, tk);
    #1;
    check_outputs(tag);
    if (done === 1'b1) d_seen++;
    if (busy === 1'b1 && tk) busy_ticks++;
    if (int'(lit_count) > peak) peak = int'(lit_count);
  endtask

  task automatic wait_idle(input bit rand_ticks, input string tag);
    int n = 0;
    do begin
      cycle(0, 0, rand_ticks ? 1'($urandom_range(0, 1)) : 1'b1, tag);
      n++;
    end while ((n < 2 || m_dir != 0 || m_arrive || m_done) && n < 400);
    chk({tag, "_timeout"}, 32'(n < 400), 32'd1);
  endtask

  task automatic start(input int tgt, input string tag);
    d_seen = 0; busy_ticks = 0; peak = 0;
    cycle(1, tgt, 1'b1, tag);
  endtask

  initial begin
    int n;
    rst = 1'b1; target = '0; target_valid = 1'b0; step_tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
    $display("txn reset: lit=%0d busy=%0b", lit_count, busy);

    // 0 -> 4 with a tick every cycle
    start(4, "up4");
    wait_idle(0, "up4");
    chk("up4_lit", 32'(lit_count), 32'd4);
    chk("up4_lamps", 32'(lamps), 32'h000F);
    chk("up4_done_once", 32'(d_seen), 32'd1);
    chk("up4_ticks", 32'(busy_ticks), 32'd16);
    $display("txn target=4: lit=%0d lamps=%h done_pulses=%0d", lit_count, lamps, d_seen);

    // 4 -> 1 ramp down
    start(1, "dn1");
    wait_idle(0, "dn1");
    chk("dn1_lamps", 32'(lamps), 32'h0001);
    chk("dn1_done_once", 32'(d_seen), 32'd1);
    chk("dn1_ticks", 32'(busy_ticks), 32'd12);
    $display("txn target=1: lit=%0d lamps=%h done_pulses=%0d", lit_count, lamps, d_seen);

    // ramp toward 8, retarget to 3 once five lamps are lit
    start(8, "rt");
    n = 0;
    while (m_lit != 5 && n < 200) begin
      cycle(0, 0, 1'b1, "rt");
      n++;
    end
    chk("rt_reach5", 32'(n < 200), 32'd1);
    cycle(1, 3, 1'b0, "rt");
    wait_idle(0, "rt");
    chk("rt_lit", 32'(lit_count), 32'd3);
    chk("rt_peak", 32'(peak), 32'd5);
    chk("rt_done_once", 32'(d_seen), 32'd1);
    $display("txn retarget 8->3: lit=%0d peak=%0d done_pulses=%0d", lit_count, peak, d_seen);

    // full scale with sparse random ticks
    start(15, "full");
    wait_idle(1, "full");
    chk("full_lamps", 32'(lamps), 32'h7FFF);
    repeat (8) cycle(0, 0, 1'b1, "full_hold");
    chk("full_nowrap", 32'(lit_count), 32'd15);
    $display("txn target=15: lit=%0d lamps=%h", lit_count, lamps);

    // target equal to the current count: nothing happens
    start(15, "same");
    repeat (10) cycle(0, 0, 1'b1, "same");
    chk("same_done", 32'(d_seen), 32'd0);
    chk("same_busy", 32'(busy_ticks), 32'd0);
    $display("txn target=15 again: busy_ticks=%0d done_pulses=%0d", busy_ticks, d_seen);

    // reset mid-ramp at six lamps lit
    start(2, "mid");
    n = 0;
    while (m_lit != 6 && n < 200) begin
      cycle(0, 0, 1'b1, "mid");
      n++;
    end
    chk("mid_reach6", 32'(n < 200), 32'd1);
    chk("mid_pre_lamps", 32'(lamps), 32'h003F);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_lamps", 32'(lamps), 32'h0000);
    chk("mid_async_lit", 32'(lit_count), 32'd0);
    chk("mid_async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    d_seen = 0; busy_ticks = 0;
    repeat (6) cycle(0, 0, 1'b1, "post_rst");
    chk("post_rst_idle", 32'(busy_ticks + d_seen), 32'd0);
    $display("txn reset mid-ramp: lamps=%h busy=%0b", lamps, busy);

    // 0 -> 10, then target 0
    start(10, "ten");
    wait_idle(0, "ten");
    start(0, "off");
    wait_idle(0, "off");
    chk("off_lit", 32'(lit_count), 32'd0);
    chk("off_done_once", 32'(d_seen), 32'd1);
`ifdef LAMP_SEQ_INSTANT_OFF_EN
    chk("off_ticks", 32'(busy_ticks), 32'd0);
`else
    chk("off_ticks", 32'(busy_ticks), 32'd40);
`endif
    $display("txn target=0 from 10: ramp_ticks=%0d done_pulses=%0d", busy_ticks, d_seen);

    // random targets, random ticks, occasional mid-ramp retargets
    for (int i = 0; i < 600; i++) begin
      bit tv;
      tv = ($urandom_range(0, 24) == 0);
      cycle(tv, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");
    end
    $display("txn random phase: lit=%0d busy=%0b", lit_count, busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
